stage5_sp4_encoder: RTL and testbench

//  Transmit-side counterpart of the stage-5 SP4 field extractor. Accepts a base message

---
 rtl/stage5_sp4_encoder.sv | 127 ++++++++++++
 tb/tb_stage5_sp4_encoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/stage5_sp4_encoder.sv
// SP4 field inserter and word serialiser: patches SP4 into a type-specific slice of the
// message image and streams the result MSW-first over a valid/ready interface.
module stage5_sp4_encoder #(
    parameter int                MSG_BITS     = 256,
    parameter int                WORD_BITS    = 32,
    parameter int                SP4_BITS     = 32,
    parameter int                A_SP4_LSB    = 64,
    parameter int                D_SP4_LSB    = 96,
    parameter int                K_SP4_LSB    = 128,
    parameter logic [1:0]        MUX_A        = 2'd1,
    parameter logic [1:0]        MUX_D        = 2'd2,
    parameter logic [1:0]        MUX_K        = 2'd3,
    parameter logic [SP4_BITS-1:0] DEFAULT_INFO = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 message_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mux_control,
    input  logic [SP4_BITS-1:0]  in_sp4,
    input  logic [MSG_BITS-1:0]  in_body,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_BITS-1:0] out_data,
    output logic                 out_last,
    output logic                 err_bad_type
);

    localparam int NWORDS = MSG_BITS / WORD_BITS;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_q, state_d;
    logic [MSG_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  err_q, err_d;

    logic [SP4_BITS-1:0]   sp4_val;
    logic [MSG_BITS-1:0]   body_ins;
    logic                  type_ok;

    always_comb begin
        sp4_val  = message_en ? in_sp4 : DEFAULT_INFO;
        body_ins = in_body;
        type_ok  = 1'b1;
        case (in_mux_control)
            MUX_A:   body_ins[A_SP4_LSB +: SP4_BITS] = sp4_val;
            MUX_D:   body_ins[D_SP4_LSB +: SP4_BITS] = sp4_val;
            MUX_K:   body_ins[K_SP4_LSB +: SP4_BITS] = sp4_val;
            default: type_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (type_ok) begin
                        shift_d     = body_ins;
                        cnt_d       = '0;
                        state_d     = SEND;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        out_last_d  = (LAST_IDX == '0);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (out_ready) begin
                    shift_d = shift_q << WORD_BITS;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (out_last_q) begin
                        state_d     = IDLE;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_last_d = ((cnt_q + CNT_W'(1)) == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign err_bad_type = err_q;
    assign out_data     = shift_q[MSG_BITS-1 -: WORD_BITS];

endmodule

// File: tb/tb_stage5_sp4_encoder.sv
// Directed and randomised scoreboard bench for stage5_sp4_encoder: expected words are queued
// at input transfer and compared against the stream as the encoder emits them.
module tb_stage5_sp4_encoder;

    logic         clk;
    logic         rst;
    logic         message_en;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mux_control;
    logic [31:0]  in_sp4;
    logic [255:0] in_body;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         err_bad_type;

    int checks   = 0;
    int failures = 0;

    // Each entry is {last, data} for one expected output word.
    logic [32:0] exp_q[$];

    stage5_sp4_encoder dut (
        .clk            (clk),
        .rst            (rst),
        .message_en     (message_en),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mux_control (in_mux_control),
        .in_sp4         (in_sp4),
        .in_body        (in_body),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .err_bad_type   (err_bad_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void pushExpected(input logic [255:0] body, input logic [1:0] code,
                                         input logic [31:0] sp4, input logic en);
        int lsb;
        logic [255:0] msg;
        logic [255:0] field;
        logic [255:0] mask;
        case (code)
            2'd1:    lsb = 64;
            2'd2:    lsb = 96;
            2'd3:    lsb = 128;
            default: return;
        endcase
        field = {224'b0, (en ? sp4 : 32'h0)};
        mask  = {224'b0, 32'hFFFF_FFFF};
        msg   = (body & ~(mask << lsb)) | (field << lsb);
        for (int i = 0; i < 8; i++)
            exp_q.push_back({(i == 7), msg[255 - 32*i -: 32]});
    endfunction

    // Caller is at a falling edge; the transfer happens at the following rising edge.
    task automatic applyStimulus(input logic [255:0] body, input logic [1:0] code,
                                 input logic [31:0] sp4, input logic en);
        checkOutput("in_ready_before_xfer", {255'b0, in_ready}, 256'd1);
        in_body        = body;
        in_mux_control = code;
        in_sp4         = sp4;
        message_en     = en;
        in_valid       = 1'b1;
        pushExpected(body, code, sp4, en);
        @(negedge clk);
        in_valid       = 1'b0;
        in_mux_control = 2'($urandom_range(3));
        in_sp4         = $urandom;
        message_en     = 1'($urandom_range(1));
        if (code == 2'd0) begin
            checkOutput("bad_err_pulse",    {255'b0, err_bad_type}, 256'd1);
            checkOutput("bad_out_valid",    {255'b0, out_valid},    256'd0);
            checkOutput("bad_in_ready",     {255'b0, in_ready},     256'd1);
            @(negedge clk);
            checkOutput("bad_err_cleared",  {255'b0, err_bad_type}, 256'd0);
            checkOutput("bad_out_valid_2",  {255'b0, out_valid},    256'd0);
            checkOutput("bad_in_ready_2",   {255'b0, in_ready},     256'd1);
        end
    endtask

    // Drives out_ready with the given percentage and scores words until the queue empties
    // or max_words transfers occur; ends at a falling edge with out_ready low.
    task automatic drainMessage(input int pct, input int max_words);
        int xfers  = 0;
        int cycles = 0;
        logic [32:0] head;
        while (exp_q.size() > 0 && xfers < max_words && cycles < 400) begin
            out_ready = ($urandom_range(99) < pct);
            head = exp_q[0];
            checkOutput("out_valid_mid",  {255'b0, out_valid}, 256'd1);
            checkOutput("in_ready_busy",  {255'b0, in_ready},  256'd0);
            checkOutput("out_data",       {224'b0, out_data},  {224'b0, head[31:0]});
            checkOutput("out_last",       {255'b0, out_last},  {255'b0, head[32]});
            if (out_ready) begin
                void'(exp_q.pop_front());
                xfers++;
            end
            @(negedge clk);
            cycles++;
        end
        out_ready = 1'b0;
        if (cycles >= 400) begin
            checkOutput("drain_timeout", 256'(cycles), 256'd0);
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            checkOutput("idle_in_ready",  {255'b0, in_ready},  256'd1);
            checkOutput("idle_out_valid", {255'b0, out_valid}, 256'd0);
        end
    endtask

    function automatic logic [255:0] randBody();
        logic [255:0] b;
        for (int i = 0; i < 8; i++)
            b[32*i +: 32] = $urandom;
        return b;
    endfunction

    initial begin
        rst            = 1'b1;
        message_en     = 1'b1;
        in_valid       = 1'b0;
        in_mux_control = 2'd0;
        in_sp4         = '0;
        in_body        = '0;
        out_ready      = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready",  {255'b0, in_ready},     256'd1);
        checkOutput("rst_out_valid", {255'b0, out_valid},    256'd0);
        checkOutput("rst_out_last",  {255'b0, out_last},     256'd0);
        checkOutput("rst_err",       {255'b0, err_bad_type}, 256'd0);
        checkOutput("rst_out_data",  {224'b0, out_data},     256'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] type a, SP4 into word 5");
        applyStimulus('0, 2'd1, 32'hDEAD_BEEF, 1'b1);
        drainMessage(100, 8);

        $display("[TB] types d and k over all-ones body");
        applyStimulus({256{1'b1}}, 2'd2, 32'h0, 1'b1);
        drainMessage(100, 8);
        applyStimulus({256{1'b1}}, 2'd3, 32'h0, 1'b1);
        drainMessage(100, 8);

        $display("[TB] message_en low inserts default");
        applyStimulus({256{1'b1}}, 2'd2, 32'h1234_5678, 1'b0);
        drainMessage(100, 8);

        $display("[TB] invalid type code");
        applyStimulus({256{1'b1}}, 2'd0, 32'hCAFE_F00D, 1'b1);

        $display("[TB] asynchronous reset mid-message");
        applyStimulus(randBody(), 2'd1, 32'hA5A5_5A5A, 1'b1);
        drainMessage(100, 3);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", {255'b0, out_valid}, 256'd0);
        checkOutput("async_rst_in_ready",  {255'b0, in_ready},  256'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(randBody(), 2'd3, 32'h0BAD_CAFE, 1'b1);
        drainMessage(100, 8);

        $display("[TB] back-pressure at 30 percent");
        for (int m = 0; m < 6; m++) begin
            applyStimulus(randBody(), 2'($urandom_range(1, 3)), $urandom, 1'($urandom_range(1)));
            drainMessage(30, 8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
